mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Arbitrates the icache and dcache miss/writeback requests onto the single-ported RAM.
//  Registered FSM holds each grant until RAM completes; returns load data and wait strobes to each cache.
//  Sits between the icache/dcache (caches_if side) and the RAM model/controller.
// PARAMETERS
//  ADDR_W       32  word address width (word_t)
//  DATA_W       32  data width (word_t)
//  STARVE_LIMIT 4   max consecutive data grants while iREN pending (MEM_ARB_STARVE_GUARD_EN only)
// PORTS
//  CLK       in  1       system clock, rising edge
//  RST       in  1       asynchronous active-high reset
//  iREN      in  1       icache read request
//  iaddr     in  ADDR_W  icache read address
//  iwait     out 1       low for exactly the cycle iload is valid
//  iload     out DATA_W  read data to icache
//  dREN      in  1       dcache read request
//  dWEN      in  1       dcache write request
//  daddr     in  ADDR_W  dcache address
//  dstore    in  DATA_W  dcache write data
//  dwait     out 1       low for exactly the cycle the data access completes
//  dload     out DATA_W  read data to dcache
//  ramREN    out 1       RAM read enable
//  ramWEN    out 1       RAM write enable
//  ramaddr   out ADDR_W  RAM address
//  ramstore  out DATA_W  RAM write data
//  ramload   in  DATA_W  RAM read data
//  ramstate  in  2       ramstate_t: FREE, BUSY, ACCESS, ERROR
//  mem_err   out 1       sticky: set when ramstate==ERROR seen during a grant
// BEHAVIOUR
//  - FSM arb_state_t: IDLE, IGNT, DGNT. RST -> IDLE, mem_err=0, starve count=0.
//  - IDLE outputs: ramREN=ramWEN=0, ramaddr=0, ramstore=0, iwait=dwait=1, iload=dload=0.
//  - Arbitration (in IDLE, and on the completion cycle of a grant): (dREN|dWEN) -> DGNT;
//    else iREN -> IGNT; else IDLE. Data has priority (memory stage stalls the whole pipe).
//  - IGNT: ramREN=1, ramaddr=iaddr. DGNT: ramaddr=daddr; dWEN=1 -> ramWEN=1, ramstore=dstore,
//    ramREN=0; else ramREN=1. dREN&dWEN together: write wins, read ignored.
//  - Completion: ramstate==ACCESS while granted -> granted wait=0 combinationally same cycle;
//    iload/dload=ramload for that cycle (0 otherwise). Next state re-arbitrated, so
//    back-to-back grants have no idle bubble.
//  - Non-granted requester's wait stays 1; its load stays 0.
//  - FREE/BUSY: hold grant, waits stay 1. ERROR: hold grant, set mem_err (cleared only by RST).
//  - Requester drops its request before ACCESS: abort, next cycle IDLE (or re-arbitrate);
//    no wait strobe issued.
//  - Grant address/data are live (not latched); caches must hold them stable until wait=0.
//  - RST mid-grant: immediately IDLE, RAM enables drop asynchronously, waits=1.
// CONFIGURATION
//  MEM_ARB_STARVE_GUARD_EN defined: counter increments on each completed DGNT while iREN=1,
//    clears on any completed IGNT or when iREN=0; at count==STARVE_LIMIT arbitration picks
//    IGNT over pending data once, then clears.
//  Undefined: strict data priority; counter not instantiated, icache may starve.
// STRUCTURE
//  - cpu_types_pkg: word_t, ramstate_t (existing); add arb_state_t enum {IDLE,IGNT,DGNT}.
//  - Sub-module mem_arb_starve_ctr (saturating counter + force_i flag), instantiated only
//    under MEM_ARB_STARVE_GUARD_EN.
// TESTING
//  1 Reset: RST=1 mid-DGNT -> ramREN=ramWEN=0, iwait=dwait=1, mem_err=0 same cycle.
//  2 iREN=1 iaddr=0x40, ramstate BUSY 2 cycles then ACCESS ramload=0xDEADBEEF -> iwait=0 and
//    iload=0xDEADBEEF in ACCESS cycle only; dwait stays 1.
//  3 iREN and dREN both 1 from IDLE -> DGNT first; after its ACCESS, IGNT next cycle, no bubble.
//  4 dWEN=1 dREN=1 daddr=0x80 dstore=0x1234 -> ramWEN=1 ramREN=0 ramstore=0x1234 until ACCESS.
//  5 ramstate=ERROR during IGNT -> mem_err=1 sticky, grant held; later ACCESS completes normally.
//  6 GUARD_EN, iREN held, 5 back-to-back data requests -> 4 data grants, then IGNT, then data.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word_t, RAM handshake states and arbiter FSM states.
// Used by mem_arbiter (MEM_ARB_STARVE_GUARD_EN selects the starvation guard).
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    IGNT,
    DGNT
  } arb_state_t;

  // force_i lets a starved icache jump ahead of pending data once
  function automatic arb_state_t arb_pick(
    input logic dreq,
    input logic ireq,
    input logic force_i
  );
    logic pick_i;
    logic pick_d;
    arb_state_t s;
    pick_i = ireq & (force_i | ~dreq);
    pick_d = dreq & ~pick_i;
    s = IDLE;
    unique case (1'b1)
      pick_d:  s = DGNT;
      pick_i:  s = IGNT;
      default: s = IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Icache starvation counter for mem_arbiter.
// Only built when MEM_ARB_STARVE_GUARD_EN is defined.
`ifdef MEM_ARB_STARVE_GUARD_EN
module mem_arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic ireq,
  input  logic d_done,
  input  logic i_done,
  output logic force_i
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (!ireq || i_done) begin
      cnt <= '0;
    end else if (d_done && cnt != CW'(LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // look ahead one completion so the forced grant follows the
  // LIMIT-th data grant without an extra data access
  always_comb begin
    force_i = 1'b0;
    if (ireq && !i_done) begin
      force_i = (cnt == CW'(LIMIT)) ||
                (d_done && cnt == CW'(LIMIT - 1));
    end
  end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// icache/dcache arbiter onto a single-ported RAM, data has priority.
// Define MEM_ARB_STARVE_GUARD_EN to bound icache starvation.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              mem_err
);

  arb_state_t state;
  arb_state_t nxt;
  logic dreq;
  logic i_done;
  logic d_done;
  logic force_i;

  assign dreq   = dREN | dWEN;
  assign i_done = (state == IGNT) && (ramstate == ACCESS) && iREN;
  assign d_done = (state == DGNT) && (ramstate == ACCESS) && dreq;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .CLK    (CLK),
    .RST    (RST),
    .ireq   (iREN),
    .d_done (d_done),
    .i_done (i_done),
    .force_i(force_i)
  );
`else
  assign force_i = (STARVE_LIMIT < 0);
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = arb_pick(dreq, iREN, force_i);
      IGNT: begin
        if (i_done || !iREN) nxt = arb_pick(dreq, iREN, force_i);
      end
      DGNT: begin
        if (d_done || !dreq) nxt = arb_pick(dreq, iREN, force_i);
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      mem_err <= 1'b0;
    end else begin
      state <= nxt;
      if (state != IDLE && ramstate == ERROR) mem_err <= 1'b1;
    end
  end

  // address and store data are live; caches hold them until wait drops
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    unique case (state)
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (i_done) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      DGNT: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = 1'b1;
        end
        if (d_done) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      default: ;
    endcase
  end

endmodule
